// File: rtl/block_div.sv
// rtl/block_div.sv - sequential restoring divider, 16-bit two's-complement product by sign-magnitude coefficient
module block_div #(
   parameter int N_BITS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N_BITS-1:0] product,
   input  logic [7:0]        biSignal,
   output logic [7:0]        quotient,
   output logic [6:0]        remainder,
   output logic              quo_neg,
   output logic              ovf,
   output logic              dz,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

   state_t            state;
   logic [N_BITS-1:0] dvd;
   logic [N_BITS-1:0] quo;
   logic [6:0]        dvs;
   logic [7:0]        rem;
   logic              sgn;
   logic [3:0]        cnt;

   logic [N_BITS-1:0] prod_abs;
   logic [7:0]        shifted;
   logic [8:0]        trial;
   logic [7:0]        rem_nx;
   logic [N_BITS-1:0] quo_nx;
   logic              quo_big;

   // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore
   always_comb begin
      prod_abs = product[N_BITS-1] ? (~product + 1'b1) : product;
      shifted  = {rem[6:0], dvd[N_BITS-1]};
      trial    = {1'b0, shifted} - {2'b00, dvs};
      rem_nx   = trial[8] ? shifted : trial[7:0];
      quo_nx   = {quo[N_BITS-2:0], ~trial[8]};
      quo_big  = |quo_nx[N_BITS-1:8];
   end

   // Control FSM with datapath and registered outputs; outputs load on entry to DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         dvd       <= '0;
         quo       <= '0;
         dvs       <= '0;
         rem       <= '0;
         sgn       <= 1'b0;
         cnt       <= '0;
         quotient  <= '0;
         remainder <= '0;
         quo_neg   <= 1'b0;
         ovf       <= 1'b0;
         dz        <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  dvd  <= prod_abs;
                  dvs  <= biSignal[6:0];
                  sgn  <= product[N_BITS-1] ^ biSignal[7];
                  rem  <= '0;
                  quo  <= '0;
                  cnt  <= '0;
                  busy <= 1'b1;
                  if (biSignal[6:0] == 7'd0) begin
                     // Zero divisor skips iteration entirely and reports saturated result
                     state     <= DONE;
                     done      <= 1'b1;
                     quotient  <= 8'hFF;
                     remainder <= '0;
                     quo_neg   <= 1'b0;
                     ovf       <= 1'b0;
                     dz        <= 1'b1;
                  end else begin
                     state <= DIV;
                  end
               end
            end
            DIV: begin
               dvd <= {dvd[N_BITS-2:0], 1'b0};
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= cnt + 4'd1;
               if (cnt == 4'(N_BITS - 1)) begin
                  // Last step: publish results so they are valid alongside done
                  state     <= DONE;
                  done      <= 1'b1;
                  quotient  <= quo_big ? 8'hFF : quo_nx[7:0];
                  ovf       <= quo_big;
                  remainder <= rem_nx[6:0];
                  quo_neg   <= sgn & (|quo_nx);
                  dz        <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
